// File: rtl/bf16_pkg.sv
// Shared types and constants for the BF16 group accumulator controller.
package bf16_pkg;

  // Field view of a BF16 value.
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] mant;
  } bf16_t;

  localparam logic [15:0] BF16_ZERO = 16'h0000;
  localparam logic [15:0] BF16_ONE  = 16'h3F80;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_OUT   = 2'd3
  } acc_state_e;

  // Saturating increment used by the optional element counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

endpackage

// File: rtl/bf16_sync_fifo.sv
// Single-clock FIFO holding {last, bf16} entries in front of the accumulator.
// DEPTH must be a power of two so the pointers wrap naturally.
module bf16_sync_fifo #(
  parameter int WIDTH = 17,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             empty,
  output logic             full
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [AW-1:0]    wr_ptr_r;
  logic [AW-1:0]    rd_ptr_r;
  logic [CW-1:0]    count_r;
  logic             wr_en_s;
  logic             rd_en_s;
  logic             empty_s;
  logic             full_s;

  assign empty_s = (count_r == {CW{1'b0}});
  assign full_s  = (count_r == CW'(DEPTH));
  // A full FIFO can still take a write when the head leaves in the same cycle.
  assign rd_en_s = pop && !empty_s;
  assign wr_en_s = push && (!full_s || rd_en_s);

  assign rdata = mem_r[rd_ptr_r];
  assign empty = empty_s;
  assign full  = full_s;

  // Storage array write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (wr_en_s) begin
      mem_r[wr_ptr_r] <= wdata;
    end
  end

  // Read/write pointers and occupancy count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (wr_en_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end
      if (rd_en_s) begin
        rd_ptr_r <= rd_ptr_r + AW'(1);
      end
      case ({wr_en_s, rd_en_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bf16_accum_ctrl.sv
// BF16 group accumulator controller: buffers incoming elements, sequences
// one add at a time through an external pipelined BF16 adder, and presents
// each group's sum with a valid/ready handshake.
// Optional feature macro: BF16_ACC_CNT_EN adds out_count (saturating group size).
module bf16_accum_ctrl
  import bf16_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_data,
  input  logic        in_last,
  output logic        add_valid,
  output logic [15:0] add_a,
  output logic [15:0] add_b,
  input  logic        add_busy,
  input  logic        add_valid_out,
  input  logic [15:0] add_result,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data
`ifdef BF16_ACC_CNT_EN
  ,
  output logic [7:0]  out_count
`endif
);

  acc_state_e  state_r;
  acc_state_e  state_nxt_s;

  logic [16:0] fifo_rdata_s;
  logic        fifo_empty_s;
  logic        fifo_full_s;
  logic        fifo_push_s;
  logic        fifo_pop_s;
  bf16_t       head_s;
  logic        head_last_s;

  logic        idle_pop_s;
  logic        issue_s;
  logic        wait_done_s;
  logic        out_take_s;

  logic [15:0] acc_r;
  logic        pend_last_r;
  logic [15:0] add_a_r;
  logic [15:0] add_b_r;
  logic        out_valid_r;
  logic [15:0] out_data_r;

  assign head_s      = fifo_rdata_s[15:0];
  assign head_last_s = fifo_rdata_s[16];
  assign fifo_push_s = in_valid && !fifo_full_s;
  assign fifo_pop_s  = idle_pop_s || issue_s;
  assign in_ready    = !fifo_full_s;

  bf16_sync_fifo #(
    .WIDTH (17),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (fifo_push_s),
    .wdata ({in_last, in_data}),
    .pop   (fifo_pop_s),
    .rdata (fifo_rdata_s),
    .empty (fifo_empty_s),
    .full  (fifo_full_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state decode and per-cycle control strobes.
  always_comb begin
    state_nxt_s = state_r;
    idle_pop_s  = 1'b0;
    issue_s     = 1'b0;
    wait_done_s = 1'b0;
    out_take_s  = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!fifo_empty_s) begin
          idle_pop_s  = 1'b1;
          state_nxt_s = head_last_s ? ST_OUT : ST_ISSUE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_ISSUE: begin
        if (!fifo_empty_s && !add_busy) begin
          issue_s     = 1'b1;
          state_nxt_s = ST_WAIT;
        end else begin
          state_nxt_s = ST_ISSUE;
        end
      end
      ST_WAIT: begin
        if (add_valid_out) begin
          wait_done_s = 1'b1;
          state_nxt_s = pend_last_r ? ST_OUT : ST_ISSUE;
        end else begin
          state_nxt_s = ST_WAIT;
        end
      end
      ST_OUT: begin
        if (out_ready) begin
          out_take_s  = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // Accumulator, pending-last flag, held adder operands and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_r       <= BF16_ZERO;
      pend_last_r <= 1'b0;
      add_a_r     <= BF16_ZERO;
      add_b_r     <= BF16_ZERO;
      out_valid_r <= 1'b0;
      out_data_r  <= BF16_ZERO;
    end else begin
      if (idle_pop_s) begin
        acc_r <= head_s;
      end else if (wait_done_s) begin
        acc_r <= add_result;
      end
      if (issue_s) begin
        add_a_r     <= acc_r;
        add_b_r     <= head_s;
        pend_last_r <= head_last_s;
      end
      if (idle_pop_s && head_last_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= head_s;
      end else if (wait_done_s && pend_last_r) begin
        out_valid_r <= 1'b1;
        out_data_r  <= add_result;
      end else if (out_take_s) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // The issue pulse lives only in the ISSUE cycle; the operand registers
  // then keep add_a/add_b steady while the adder works on them.
  assign add_valid = issue_s;
  assign add_a     = issue_s ? acc_r  : add_a_r;
  assign add_b     = issue_s ? head_s : add_b_r;
  assign out_valid = out_valid_r;
  assign out_data  = out_data_r;

`ifdef BF16_ACC_CNT_EN
  logic [7:0] cnt_r;

  // Elements taken into the current group; cleared when returning to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= 8'd0;
    end else if (out_take_s) begin
      cnt_r <= 8'd0;
    end else if (fifo_pop_s) begin
      cnt_r <= sat_inc8(cnt_r);
    end
  end

  assign out_count = cnt_r;
`endif

endmodule

// File: doc/bf16_accum_ctrl.md
BF16_ACCUM_CTRL -- requirements
Module: bf16_accum_ctrl

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, input FIFO entries (power of 2, >=2).
REQ-002 SHALL have ports:
  clk  input  1  clock, all state on rising edge.
  rst_n  input  1  reset, asynchronous, active-low.
  in_valid  input  1  input element valid.
  in_ready  output  1  FIFO not full.
  in_data  input  16  BF16 element.
  in_last  input  1  last element of the current group.
  add_valid  output  1  one-cycle issue pulse to the pipelined BF16 adder.
  add_a  output  16  adder operand A (accumulator).
  add_b  output  16  adder operand B (new element).
  add_busy  input  1  adder busy.
  add_valid_out  input  1  adder result strobe.
  add_result  input  16  adder sum.
  out_valid  output  1  group sum valid.
  out_ready  input  1  consumer accepts sum.
  out_data  output  16  BF16 group sum.

Function
REQ-003 SHALL push {in_last,in_data} into the FIFO on in_valid && in_ready; in_ready = !full.
REQ-004 SHALL implement states IDLE, ISSUE, WAIT, OUT.
REQ-005 IDLE, FIFO non-empty: pop the head into acc; if its last bit is set go to OUT, else go to ISSUE.
REQ-006 ISSUE, FIFO non-empty and !add_busy:
  - drive add_valid=1 for exactly one cycle, add_a=acc, add_b=head data;
  - pop the head, latch its last bit into pend_last, go to WAIT.
REQ-007 ISSUE, FIFO empty or add_busy: hold state with add_valid=0.
REQ-008 WAIT, add_valid_out=1:
  - acc <= add_result;
  - go to OUT if pend_last, else ISSUE.
  - Expected gap is 4 cycles after the issue pulse; no timeout.
REQ-009 OUT:
  - out_valid=1, out_data=acc, both held stable until out_ready;
  - on out_valid && out_ready go to IDLE.
REQ-010 add_a/add_b SHALL be held stable from the issue pulse until add_valid_out.
REQ-011 add_valid SHALL never assert while add_busy=1 or in WAIT/OUT; at most one add is in flight.
REQ-012 The FIFO SHALL accept pushes in every state, including push and pop in the same cycle when full; pointers wrap modulo FIFO_DEPTH.
REQ-013 add_valid_out outside WAIT SHALL be ignored.
REQ-014 The block SHALL perform no arithmetic itself; rounding, FTZ and overflow to Inf follow the adder.
REQ-015 Group throughput SHALL be N-1 adds for N elements; a single-element group is passed through unchanged.

Reset
REQ-016 On rst_n low, asynchronously:
  - state=IDLE, FIFO pointers and count=0;
  - acc=0, pend_last=0;
  - add_valid=0, out_valid=0, add_a=add_b=out_data=0x0000;
  - in_ready=1 in the first cycle after release.
REQ-017 Reset mid-group SHALL discard the partial sum and FIFO contents; a late add_valid_out after release is ignored per REQ-013.

Configuration
REQ-018 With BF16_ACC_CNT_EN defined:
  - add output out_count[7:0], the element count of the group, valid with out_valid;
  - the counter saturates at 255 and clears on IDLE entry.
REQ-019 Without BF16_ACC_CNT_EN: no out_count port and no counter logic.

Structure
REQ-020 A shared package bf16_pkg SHALL hold:
  - the bf16_t struct (sign, exp[7:0], mant[6:0]);
  - constants BF16_ZERO=0x0000, BF16_ONE=0x3F80;
  - the state enum type.
REQ-021 The FIFO SHALL be the sub-module bf16_sync_fifo (parameters WIDTH=17, DEPTH), instantiated once.

Verification
REQ-022 Group 0x3F80, 0x4000, 0x3F00 (last) with the adder model -> exactly 2 add_valid pulses, out_data=0x4060 (3.5).
REQ-023 Single element 0x4000 with in_last=1 -> no add_valid, out_valid with out_data=0x4000 within 2 cycles.
REQ-024 Group 0x4000, 0xBF80 (last) -> add_a=0x4000, add_b=0xBF80, out_data=0x3F80.
REQ-025 Push 6 elements back-to-back with FIFO_DEPTH=4 while an add is in flight -> in_ready deasserts after 4 entries, no element lost, final sum correct.
REQ-026 out_ready held low 5 cycles -> out_valid and out_data stable; the next group's adds do not start until the handshake completes.
REQ-027 rst_n pulsed low during WAIT -> all outputs zero immediately; the following add_valid_out is ignored; a new group 0x3F80, 0x3F80 (last) -> 0x4000.
